// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: the NOP that
// decode sees when nothing is queued, the fetch state encoding, and the
// queue entry layout (instruction word plus the PC it was fetched from).
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // A fetch target is usable only when it sits on a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched words with their PCs. The head is
// read straight from the storage array, so a word pushed at one edge is
// visible at the output in the following cycle. Flush wins over push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_wdata,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Entry storage: data only, never needs clearing because occupancy guards it.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; a flush simply rewinds everything to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // A push into a full queue is legal only when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && o_full && !i_pop));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order word requests to instruction
// memory under a credit limit, tags returning words with their request PC
// and queues them for decode. Redirects flush the queue and mark every
// response still in flight as stale. A misaligned redirect target parks the
// stage in FAULT until execute supplies an aligned one.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        misaligned
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic          r_misaligned;

    // PCs of requests accepted by memory, oldest first; consumed one per response.
    logic [31:0]   r_pcq [QUEUE_DEPTH];
    logic [AW-1:0] r_pcq_wr;
    logic [AW-1:0] r_pcq_rd;

    logic          w_accept;
    logic          w_rsp;
    logic          w_keep;
    logic          w_pop;
    logic          w_redir_aligned;
    logic [SW-1:0] w_in_use;
    logic          w_credit_ok;
    logic          w_q_full;
    logic          w_q_empty;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Slots committed to requests in flight or words waiting in the queue.
    // The word decode takes this cycle frees its slot at the coming edge, and
    // any new response lands at least one cycle later, so that slot can be
    // re-issued now; this is what keeps a one-cycle memory at full rate.
    assign w_in_use    = SW'(r_outstanding) + SW'(r_count) - SW'(w_pop);
    assign w_credit_ok = (w_in_use < SW'(QUEUE_DEPTH));

    assign imem_req_valid  = rst_n && (r_state == FETCH) && w_credit_ok && !redirect_valid;
    assign imem_addr       = r_pc;
    assign w_accept        = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding cannot belong to this stage; ignore it.
    assign w_rsp           = imem_rsp_valid && (r_outstanding != '0);
    assign w_keep          = w_rsp && (r_drop == '0);
    assign w_redir_aligned = redirect_valid && is_word_aligned(redirect_pc[1:0]);

    assign w_pop           = !w_q_empty && instr_ready;
    assign w_push_entry    = '{instr: imem_rsp_data, pc: r_pcq[r_pcq_rd]};

    assign instr_valid = !w_q_empty;
    assign instruction = w_q_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc    = w_q_empty ? 32'h0000_0000 : w_head.pc;
    assign misaligned  = r_misaligned;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_head  (w_head)
    );

    // Request-PC storage: written on acceptance, no clearing needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
    end

    // Request-PC pointers; stale entries are still consumed as their responses arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
        end else begin
            if (w_accept) begin
                r_pcq_wr <= r_pcq_wr + AW'(1);
            end
            if (w_rsp) begin
                r_pcq_rd <= r_pcq_rd + AW'(1);
            end
        end
    end

    // Fetch FSM with PC, credit counters, stale-response count and fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);

            if (redirect_valid) begin
                // Everything still in flight now belongs to the old path, except
                // a response retiring this very cycle, which the flush discards.
                r_count <= '0;
                r_drop  <= r_outstanding - CW'(w_rsp);
            end else begin
                r_count <= r_count + CW'(w_keep) - CW'(w_pop);
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end

            case (r_state)
                FETCH: begin
                    if (redirect_valid && !w_redir_aligned) begin
                        r_state      <= FAULT;
                        r_misaligned <= 1'b1;
                    end else if (w_redir_aligned) begin
                        r_pc <= redirect_pc;
                    end else if (w_accept) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                FAULT: begin
                    if (w_redir_aligned) begin
                        r_state      <= FETCH;
                        r_misaligned <= 1'b0;
                        r_pc         <= redirect_pc;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // The credit counter must always agree with the queue's own occupancy.
    a_count_sync: assert property (@(posedge clk) disable iff (!rst_n)
        (w_q_full == (r_count == CW'(QUEUE_DEPTH))) && (w_q_empty == (r_count == '0)));

endmodule
